// File: rtl/fetch_unit_pkg.sv
// Core constants shared by the fetch stage: instruction width, reset PC, NOP encoding.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order FIFO with synchronous flush; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches, tracks in-flight requests, buffers
// responses with their PCs, and discards stale responses after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] last_pc;
    logic [1:0]      outstanding;
    logic [1:0]      drop;
    logic [2:0]      in_use;
    logic            grant;
    logic            resp_keep;

    logic [XLEN-1:0] addr_head;
    logic            addr_full;
    logic            addr_empty;
    logic [1:0]      addr_count;

    fetch_entry_t    data_head;
    logic            data_full;
    logic            data_empty;
    logic [1:0]      data_count;
    logic            unused_status;

    // Outstanding includes responses still to be dropped, so one sum covers both the
    // normal and the post-redirect space accounting.
    assign in_use     = {1'b0, outstanding} + {1'b0, data_count};
    assign imem_req_o = !rst && !flush_i && (in_use < 3'd2);
    assign imem_addr_o = pc;
    assign grant      = imem_req_o && imem_gnt_i;
    assign resp_keep  = imem_rvalid_i && (drop == 2'd0);

    assign if_valid_o = !data_empty;
    assign if_pc_o    = if_valid_o ? data_head.pc    : last_pc;
    assign if_instr_o = if_valid_o ? data_head.instr : NOP_INSTR;

    assign unused_status = ^{addr_full, addr_empty, addr_count, data_full};

    fetch_fifo #(.WIDTH(XLEN)) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (grant),
        .pop   (resp_keep),
        .wdata (pc),
        .rdata (addr_head),
        .full  (addr_full),
        .empty (addr_empty),
        .count (addr_count)
    );

    fetch_fifo #(.WIDTH(2 * XLEN)) u_data_q (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (resp_keep && !flush_i),
        .pop   (if_valid_o && !stall_i),
        .wdata ({addr_head, imem_rdata_i}),
        .rdata (data_head),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= align_word(RESET_PC);
            last_pc     <= RESET_PC;
            outstanding <= 2'd0;
            drop        <= 2'd0;
        end else begin
            if (if_valid_o) begin
                last_pc <= data_head.pc;
            end
            outstanding <= outstanding + {1'b0, grant} - {1'b0, imem_rvalid_i};
            if (flush_i) begin
                pc   <= align_word(redirect_pc_i);
                drop <= outstanding - {1'b0, imem_rvalid_i};
            end else begin
                if (grant) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rvalid_i && (drop != 2'd0)) begin
                    drop <= drop - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-bench memory responder plus a scoreboard of
// expected {pc, instr} in program order, consumed by an independent output monitor.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t       pend_q[$];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    logic [31:0] model_pc = RPC;
    logic [31:0] last_pc = RPC;
    bit          hold = 0;
    bit          granted = 0;
    bit          prev_flush = 0;
    int unsigned resp_pct = 100;
    int unsigned extra_max = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive inputs after negedge, then account for any grant.
    task automatic cycle(input bit r, input bit st, input bit fl, input logic [31:0] rp, input bit g);
        int unsigned stale_n;
        @(negedge clk);
        cyc++;
        if (r) pend_q.delete();
        rst           = r;
        stall_i       = st;
        flush_i       = fl;
        redirect_pc_i = rp;
        imem_gnt_i    = g;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (!r && !hold && pend_q.size() > 0 && pend_q[0].due <= cyc
            && $urandom_range(99) < resp_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        #1;
        granted = 0;
        if (r) begin
            exp_q.delete();
            model_pc = RPC;
        end else if (fl) begin
            chk("req_during_flush", imem_req_o, 0);
            model_pc = {rp[31:2], 2'b00};
            foreach (pend_q[i]) pend_q[i].stale = 1;
        end else begin
            if (imem_req_o) chk("fetch_addr", imem_addr_o, model_pc);
            if (imem_req_o && g) begin
                exp_q.push_back('{model_pc, mem_word(model_pc)});
                pend_q.push_back('{model_pc, cyc + 1 + $urandom_range(extra_max), 0});
                model_pc += 32'd4;
                granted = 1;
                stale_n = 0;
                foreach (pend_q[i]) if (pend_q[i].stale) stale_n++;
                chk("space_bound", 32'(exp_q.size() + stale_n <= 2), 1);
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        hold     = 0;
        resp_pct = 100;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 100) begin
            cycle(0, 0, 0, '0, 0);
            n++;
        end
        chk({"drain_", tag}, 32'(exp_q.size() + pend_q.size()), 0);
    endtask

    // Output monitor: every presented instruction must be the oldest expected one.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            last_pc    = RPC;
            prev_flush = 0;
        end else begin
            if (prev_flush) chk("valid_after_flush", if_valid_o, 0);
            if (if_valid_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got pc %h instr %h expected nothing (cycle %0d)",
                             if_pc_o, if_instr_o, cyc);
                end else begin
                    chk("if_pc", if_pc_o, exp_q[0].pc);
                    chk("if_instr", if_instr_o, exp_q[0].instr);
                    last_pc = exp_q[0].pc;
                    if (!stall_i && !flush_i) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_instr", if_instr_o, NOP);
                chk("idle_pc", if_pc_o, last_pc);
            end
            if (flush_i) exp_q.delete();
            prev_flush = flush_i;
        end
    end

    initial begin
        logic [31:0] held;
        logic [31:0] rp;
        bit          r;

        repeat (2) cycle(1, 0, 0, '0, 1);
        chk("rst_req", imem_req_o, 0);
        chk("rst_valid", if_valid_o, 0);
        chk("rst_instr", if_instr_o, NOP);
        chk("rst_pc", if_pc_o, RPC);

        // First fetch: grant immediately, response one cycle later.
        cycle(0, 0, 0, '0, 1);
        chk("first_grant", granted, 1);
        chk("first_addr", imem_addr_o, 32'h0);
        cycle(0, 0, 0, '0, 1);
        chk("first_valid_early", if_valid_o, 0);
        cycle(0, 0, 0, '0, 1);
        chk("first_valid", if_valid_o, 1);
        chk("first_if_pc", if_pc_o, 32'h0);
        repeat (20) cycle(0, 0, 0, '0, 1);

        // Downstream stall with continuous grants.
        repeat (5) cycle(0, 1, 0, '0, 1);
        chk("req_blocked_in_stall", imem_req_o, 0);
        repeat (10) cycle(0, 0, 0, '0, 1);

        // Delayed grant: address must hold.
        held = model_pc;
        repeat (3) begin
            cycle(0, 0, 0, '0, 0);
            chk("held_addr", imem_addr_o, held);
        end
        cycle(0, 0, 0, '0, 1);
        chk("late_grant", granted, 1);
        drain("a");

        // Redirect with two requests in flight.
        hold = 1;
        repeat (2) cycle(0, 0, 0, '0, 1);
        chk("two_in_flight", 32'(pend_q.size()), 2);
        cycle(0, 0, 1, 32'h0000_0103, 0);
        hold = 0;
        cycle(0, 0, 0, '0, 0);
        chk("redirect_addr", imem_addr_o, 32'h0000_0100);
        repeat (10) cycle(0, 0, 0, '0, 1);
        drain("b");

        // Redirect coinciding with a response while stalled.
        hold = 1;
        repeat (2) cycle(0, 0, 0, '0, 1);
        hold = 0;
        cycle(0, 1, 1, 32'h0000_2000, 0);
        chk("resp_with_flush", imem_rvalid_i, 1);
        repeat (10) cycle(0, 0, 0, '0, 1);
        drain("c");

        // PC wrap at the top of the address space.
        cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 0, 0, '0, 1);
        chk("top_grant", granted, 1);
        cycle(0, 0, 0, '0, 0);
        chk("wrap_addr", imem_addr_o, 32'h0000_0000);
        drain("d");

        // Randomized traffic with stalls, redirects, variable latency and rare resets.
        resp_pct  = 70;
        extra_max = 3;
        repeat (2000) begin
            r  = ($urandom_range(299) == 0);
            rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            cycle(r, $urandom_range(99) < 30, !r && $urandom_range(99) < 4, rp,
                  $urandom_range(99) < 70);
        end
        drain("end");
        repeat (3) cycle(0, 0, 0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
